// File: rtl/pingpong_pkg.sv
// Shared ping-pong definitions: button indices and the per-channel repeat state encoding.
package pingpong_pkg;

  localparam int unsigned NUM_BTN = 4;

  localparam int unsigned BTN_P1L = 0;
  localparam int unsigned BTN_P1R = 1;
  localparam int unsigned BTN_P2L = 2;
  localparam int unsigned BTN_P2R = 3;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    DELAY    = 2'd1,
    REPEAT   = 2'd2
  } rep_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debouncer, press pulse and step pulse generator.
// BUTTON_AUTO_REPEAT_EN builds the hold-to-repeat FSM; otherwise step mirrors press.
module button_channel
  import pingpong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic step
);

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_channel: cycle parameters must be >= 1");
  end

  logic        sync1, sync2;
  logic        st;
  logic [31:0] dcnt;
  logic        level_q;
  logic        press_q;
  logic        press_evt;
  logic        rel_now;

  // st has just gone low but level has not caught up yet: first cycle of an accepted press.
  assign press_evt = ~st & ~level_q;
  // st is being flipped back to released on this very edge.
  assign rel_now   = ~st & sync2 & (dcnt == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      st      <= 1'b1;
      dcnt    <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (sync2 != st) begin
        if (dcnt == DB_LAST) begin
          st   <= sync2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 32'd1;
        end
      end else begin
        dcnt <= '0;
      end
      level_q <= ~st;
      press_q <= press_evt;
    end
  end

  assign level = level_q;
  assign press = press_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);

  rep_state_e  state_q, state_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        step_q, step_d;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    step_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (press_evt && !rel_now) begin
          step_d  = 1'b1;
          rcnt_d  = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        // A release landing on the same edge as a due repeat wins.
        if (st || rel_now) begin
          rcnt_d  = '0;
          state_d = RELEASED;
        end else if (rcnt_q == RD_LAST) begin
          step_d  = 1'b1;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      REPEAT: begin
        if (st || rel_now) begin
          rcnt_d  = '0;
          state_d = RELEASED;
        end else if (rcnt_q == RP_LAST) begin
          step_d = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      default: begin
        rcnt_d  = '0;
        state_d = RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      rcnt_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = press_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw active-low player buttons into level, press and step outputs.
// Hold-to-repeat stepping is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner
  import pingpong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] step
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .btn_n(btn_n[i]),
      .level(level[i]),
      .press(press[i]),
      .step (step[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed checks of button_conditioner against a sample-history reference model.
module tb_button_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n;
  logic [3:0] level, press, step;

  int vectors     = 0;
  int miscompares = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn_n(btn_n),
    .level(level),
    .press(press),
    .step (step)
  );

  always #5 clk = ~clk;

  // Reference model: a button state flips once the last D samples that have cleared the
  // two-sample synchroniser delay all disagree with it; outputs follow one edge later.
  int unsigned cyc;
  logic [3:0]  m_s, m_fell, m_active;
  int unsigned m_pcyc [4];
  logic [31:0] m_hist [4];
  logic [3:0]  e_level, e_press, e_step;

  task automatic model_reset();
    m_s      = 4'hf;
    m_fell   = 4'h0;
    m_active = 4'h0;
    e_level  = 4'h0;
    e_press  = 4'h0;
    e_step   = 4'h0;
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = '1;
      m_pcyc[b] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic        s_prev, flip;
    int unsigned el;
    cyc++;
    for (int b = 0; b < 4; b++) begin
      s_prev = m_s[b];
      flip   = 1'b1;
      for (int j = 1; j <= int'(D); j++) if (m_hist[b][j] == s_prev) flip = 1'b0;
      e_press[b] = m_fell[b];
      m_fell[b]  = flip & s_prev;
      if (flip) m_s[b] = ~s_prev;
      e_level[b] = ~s_prev;
      if (e_press[b]) begin
        m_active[b] = 1'b1;
        m_pcyc[b]   = cyc;
      end
      if (m_s[b]) m_active[b] = 1'b0;
      el = cyc - m_pcyc[b];
`ifdef BUTTON_AUTO_REPEAT_EN
      e_step[b] = m_active[b] && (el == 0 || (el >= RD && (el - RD) % RP == 0));
`else
      e_step[b] = e_press[b];
`endif
      m_hist[b] = {m_hist[b][30:0], raw[b]};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(btn_n);
    @(negedge clk);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL idle t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press, step,
                 e_level, e_press, e_step);
      end
    end
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b1;
    btn_n = 4'h0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_hold: l/p/s got %b/%b/%b want all zero", level, press, step);
      end
    end
    reset = 1'b0;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL reset_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (press === 4'hf && first < 0) first = i;
    end
    vectors++;
    if (first != int'(D) + 3) begin
      miscompares++;
      $display("FAIL reset_press_latency: got %0d want %0d", first, D + 3);
    end
    btn_n = 4'hf;
    run_idle(20);
  endtask

  task automatic test_bounce();
    int cnt, at;
    btn_n[0] = 1'b0;
    run_idle(3);
    btn_n[0] = 1'b1;
    run_idle(1);
    btn_n[0] = 1'b0;
    cnt = 0;
    at  = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL bounce_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (press[0]) begin
        cnt++;
        at = i;
      end
    end
    vectors++;
    if (cnt != 1 || at != int'(D) + 3 || level[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_press: count %0d at %0d level %b, want 1 at %0d level 1", cnt, at,
               level[0], D + 3);
    end
    btn_n[0] = 1'b1;
    run_idle(15);
  endtask

  task automatic test_hold();
    int st_t [4];
    int nst, npr, pr_at;
    btn_n[2] = 1'b0;
    nst   = 0;
    npr   = 0;
    pr_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL hold_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (press[2]) begin
        npr++;
        pr_at = i;
      end
      if (step[2]) begin
        if (nst < 4) st_t[nst] = i;
        nst++;
      end
    end
    vectors++;
    if (npr != 1 || nst < 1 || pr_at != int'(D) + 3 || st_t[0] != pr_at) begin
      miscompares++;
      $display("FAIL hold_first: presses %0d at %0d, steps %0d, want 1 press at %0d with step",
               npr, pr_at, nst, D + 3);
    end
`ifdef BUTTON_AUTO_REPEAT_EN
    vectors++;
    if (nst < 4 || st_t[1] - st_t[0] != int'(RD) || st_t[2] - st_t[1] != int'(RP) ||
        st_t[3] - st_t[2] != int'(RP)) begin
      miscompares++;
      $display("FAIL hold_spacing: steps %0d, want spacing %0d,%0d,%0d", nst, RD, RP, RP);
    end
`else
    vectors++;
    if (nst != 1) begin
      miscompares++;
      $display("FAIL hold_single_step: got %0d steps want 1", nst);
    end
`endif
    btn_n[2] = 1'b1;
    run_idle(20);
  endtask

  task automatic test_release_delay();
    int t, nst, fall;
    btn_n[1] = 1'b0;
    t = -1;
    for (int i = 1; i <= 20 && t < 0; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL reldly_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (step[1]) t = i;
    end
    vectors++;
    if (t < 0) begin
      miscompares++;
      $display("FAIL reldly_first_step: got none want one within 20 cycles");
    end
    run_idle(4);
    btn_n[1] = 1'b1;
    nst  = 0;
    fall = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL reldly_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (step[1]) nst++;
      if (!level[1] && fall < 0) fall = i;
    end
    vectors++;
    if (nst != 0 || fall != int'(D) + 3) begin
      miscompares++;
      $display("FAIL reldly_release: steps %0d fall at %0d, want 0 steps fall at %0d", nst, fall,
               D + 3);
    end
    run_idle(5);
  endtask

  task automatic test_independence();
    int p0, p3, others;
    btn_n = 4'b0110;
    p0     = -1;
    p3     = -1;
    others = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL indep_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (press[0]) p0 = i;
      if (press[3]) p3 = i;
      if (press[1] || press[2] || level[1] || level[2]) others++;
    end
    vectors++;
    if (p0 < 0 || p0 != p3 || others != 0) begin
      miscompares++;
      $display("FAIL indep_press: p0 at %0d p3 at %0d others %0d, want equal and 0 others", p0,
               p3, others);
    end
    btn_n = 4'hf;
    run_idle(15);
  endtask

  task automatic test_macro_hold();
    int nst, pr_at, bad_coinc, want;
    btn_n[1] = 1'b0;
    nst       = 0;
    pr_at     = -1;
    bad_coinc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL mhold_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
      if (step[1]) nst++;
      if (press[1]) pr_at = i;
      if (press[1] && !step[1]) bad_coinc++;
    end
`ifdef BUTTON_AUTO_REPEAT_EN
    want = (40 - pr_at >= int'(RD)) ? 2 + (40 - pr_at - int'(RD)) / int'(RP) : 1;
`else
    want = 1;
`endif
    vectors++;
    if (pr_at < 0 || nst != want || bad_coinc != 0) begin
      miscompares++;
      $display("FAIL mhold_steps: got %0d steps (press at %0d, uncovered %0d) want %0d", nst,
               pr_at, bad_coinc, want);
    end
    btn_n[1] = 1'b1;
    run_idle(15);
  endtask

  task automatic test_random();
    int hold [4];
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          btn_n[b] = 1'($urandom_range(0, 1));
          hold[b]  = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
        end else begin
          hold[b]--;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({level, press, step} !== 12'h000) begin
          miscompares++;
          $display("FAIL async_reset: l/p/s got %b/%b/%b want all zero", level, press, step);
        end
        run_idle(2);
        reset = 1'b0;
      end
      tick();
      vectors++;
      if ({level, press, step} !== {e_level, e_press, e_step}) begin
        miscompares++;
        $display("FAIL random_model t=%0d: l/p/s got %b/%b/%b want %b/%b/%b", cyc, level, press,
                 step, e_level, e_press, e_step);
      end
    end
    btn_n = 4'hf;
    run_idle(20);
  endtask

  initial begin
    cyc   = 0;
    reset = 1'b1;
    btn_n = 4'hf;
    model_reset();
    @(negedge clk);
    test_reset();
    test_bounce();
    test_hold();
    test_release_delay();
    test_independence();
    test_macro_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
